seq_detector_param: RTL



---
 rtl/seq_detector_param_if.sv | 27 ++
 rtl/seq_detector_param.sv | 86 ++++++++
 2 files changed

// File: rtl/seq_detector_param_if.sv
// Bus bundle for the serial pattern detector: bit stream, pattern load,
// counter clear, and the detector's match flag and match count.
interface seq_detector_param_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             in;
    logic             in_valid;
    logic             overlap;
    logic [PAT_W-1:0] pat;
    logic             pat_load;
    logic             cnt_clr;
    logic             out;
    logic [CNT_W-1:0] match_cnt;

    // Producer / control side
    modport master (
        output in, in_valid, overlap, pat, pat_load, cnt_clr,
        input  out, match_cnt
    );

    // Detector side
    modport slave (
        input  in, in_valid, overlap, pat, pat_load, cnt_clr,
        output out, match_cnt
    );
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector with a runtime-loadable pattern,
// selectable overlapping/non-overlapping detection and a saturating match
// counter. The match flag is a registered Moore output.
module seq_detector_param #(
    parameter int               PAT_W    = 4,
    parameter logic [PAT_W-1:0] PAT_INIT = 4'b1011,
    parameter int               CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    seq_detector_param_if.slave bus
);
    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic [PAT_W-1:0]  pat_q,  pat_d;
    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              out_q,  out_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;

    logic [PAT_W-1:0]  hist_n;
    logic [FILL_W-1:0] fill_n;
    logic              hit;

    assign bus.out       = out_q;
    assign bus.match_cnt = cnt_q;

    // Candidate history/fill if the current bit is accepted; fill saturates
    // so a fully primed window stays primed in overlapping mode.
    assign hist_n = {hist_q[PAT_W-2:0], bus.in};
    assign fill_n = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);

    // Next-state: pattern load beats an accepted bit; counter clear beats a hit.
    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        out_d  = out_q;
        cnt_d  = cnt_q;
        hit    = 1'b0;

        if (bus.pat_load) begin
            pat_d  = bus.pat;
            hist_d = '0;
            fill_d = '0;
            out_d  = 1'b0;
        end else if (bus.in_valid) begin
            // The fill qualifier keeps a zeroed history from matching an
            // all-zeros pattern before PAT_W real bits have arrived.
            hit   = (fill_n == FILL_FULL) && (hist_n == pat_q);
            out_d = hit;
            if (hit && !bus.overlap) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = hist_n;
                fill_d = fill_n;
            end
        end

        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with immediate return to the power-on pattern on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q  <= PAT_INIT;
            hist_q <= '0;
            fill_q <= '0;
            out_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            out_q  <= out_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule
